// File: rtl/multi_bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_bit_synchronizer
//  Description : Per-channel CDC input conditioner: STAGES-deep flop
//                synchroniser, optional stability-count glitch filter and
//                registered rise/fall edge pulses. Channels are independent;
//                not for multi-bit data words.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_bit_synchronizer #(
   parameter int unsigned      WIDTH      = 1,
   parameter int unsigned      STAGES     = 2,
   parameter int unsigned      FILTER_LEN = 0,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_sync_out,
   output logic [WIDTH-1:0] sig_filt_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   // Reject illegal configurations at elaboration time.
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("multi_bit_synchronizer: STAGES must be within 2..4");
   end
   if (FILTER_LEN > 255) begin : g_bad_filter
      $error("multi_bit_synchronizer: FILTER_LEN must be within 0..255");
   end

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] filt_d;   // value sig_filt_out will take after the next edge
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   // Plain flop chain; no logic between stages so metastability can settle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < int'(STAGES); s++) begin
            sync_q[s] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= sig_in;
         for (int s = 1; s < int'(STAGES); s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign sig_sync_out = sync_q[STAGES-1];

   if (FILTER_LEN == 0) begin : g_bypass
      // Filter off: the filtered level is the synchronised level, and its next
      // value is simply what the last-but-one stage holds now.
      assign sig_filt_out = sig_sync_out;
      assign filt_d       = sync_q[STAGES-2];
   end else begin : g_filter
      localparam int            CW     = $clog2(FILTER_LEN + 1);
      localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

      logic [WIDTH-1:0] filt_q;
      logic [CW-1:0]    cnt_q [WIDTH];
      logic [CW-1:0]    cnt_d [WIDTH];

      // Count consecutive cycles of disagreement; accept the new level on the
      // N-th one, clear the count on any agreement so glitches are dropped.
      always_comb begin
         filt_d = filt_q;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sig_sync_out[i] != filt_q[i]) begin
               if (cnt_q[i] == C_LAST) begin
                  filt_d[i] = sig_sync_out[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
         end
      end

      // Filter state registers.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            filt_q <= RESET_VAL;
            for (int i = 0; i < int'(WIDTH); i++) begin
               cnt_q[i] <= '0;
            end
         end else begin
            filt_q <= filt_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
               cnt_q[i] <= cnt_d[i];
            end
         end
      end

      assign sig_filt_out = filt_q;
   end

   // Pulses are computed from the upcoming filtered value so they are high in
   // the same cycle the new level first appears on sig_filt_out.
   assign rise_d = filt_d & ~sig_filt_out;
   assign fall_d = ~filt_d & sig_filt_out;

   // Edge pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_bit_synchronizer
//  Description : Directed self-checking bench for multi_bit_synchronizer using
//                four differently parameterised instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_bit_synchronizer;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   // A: WIDTH=2, STAGES=3, bypass, RESET_VAL=2'b10
   logic [1:0] a_in = 2'b01;
   logic [1:0] a_sync, a_filt, a_rise, a_fall;
   // B: WIDTH=1, STAGES=2, FILTER_LEN=4
   logic [0:0] b_in = 1'b0;
   logic [0:0] b_sync, b_filt, b_rise, b_fall;
   // C: WIDTH=4, STAGES=2, FILTER_LEN=2
   logic [3:0] c_in = 4'b0000;
   logic [3:0] c_sync, c_filt, c_rise, c_fall;
   // D: WIDTH=1, STAGES=2, FILTER_LEN=8
   logic [0:0] d_in = 1'b0;
   logic [0:0] d_sync, d_filt, d_rise, d_fall;

   int checks = 0;
   int failures = 0;

   int a_rise_n = 0, a_fall_n = 0;
   int b_rise_n = 0, b_fall_n = 0;
   int c_quiet_n = 0, c3_rise_n = 0;
   int s0, s1, s2, s3;

   always #5 clk = ~clk;

   multi_bit_synchronizer #(.WIDTH(2), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(2'b10)) u_a (
      .clk(clk), .reset_n(reset_n), .sig_in(a_in), .sig_sync_out(a_sync),
      .sig_filt_out(a_filt), .rise_pulse(a_rise), .fall_pulse(a_fall));
   multi_bit_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .sig_in(b_in), .sig_sync_out(b_sync),
      .sig_filt_out(b_filt), .rise_pulse(b_rise), .fall_pulse(b_fall));
   multi_bit_synchronizer #(.WIDTH(4), .STAGES(2), .FILTER_LEN(2), .RESET_VAL(4'b0000)) u_c (
      .clk(clk), .reset_n(reset_n), .sig_in(c_in), .sig_sync_out(c_sync),
      .sig_filt_out(c_filt), .rise_pulse(c_rise), .fall_pulse(c_fall));
   multi_bit_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER_LEN(8), .RESET_VAL(1'b0)) u_d (
      .clk(clk), .reset_n(reset_n), .sig_in(d_in), .sig_sync_out(d_sync),
      .sig_filt_out(d_filt), .rise_pulse(d_rise), .fall_pulse(d_fall));

   // Pulse/activity counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (a_rise != 2'b00) a_rise_n++;
      if (a_fall != 2'b00) a_fall_n++;
      if (b_rise != 1'b0)  b_rise_n++;
      if (b_fall != 1'b0)  b_fall_n++;
      if ((c_filt[2:0] | c_rise[2:0] | c_fall[2:0]) != 3'b000) c_quiet_n++;
      if (c_rise[3]) c3_rise_n++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---------------- reset values ----------------
      step(3);
      check("a_sync_rst", 32'(a_sync), 32'h2);
      check("a_filt_rst", 32'(a_filt), 32'h2);
      check("a_rise_rst", 32'(a_rise), 32'h0);
      check("a_fall_rst", 32'(a_fall), 32'h0);
      check("b_filt_rst", 32'(b_filt), 32'h0);
      a_in = 2'b10;
      s0 = a_rise_n; s1 = a_fall_n;
      reset_n = 1'b1;
      step(8);
      check("a_sync_idle", 32'(a_sync), 32'h2);
      check("a_no_rise_after_rel", 32'(a_rise_n - s0), 32'h0);
      check("a_no_fall_after_rel", 32'(a_fall_n - s1), 32'h0);

      // ---------------- latency, STAGES=3 bypass ----------------
      a_in = 2'b11;
      step(1);
      check("lat_e1", 32'(a_sync), 32'h2);
      step(1);
      check("lat_e2", 32'(a_sync), 32'h2);
      step(1);
      check("lat_e3_sync", 32'(a_sync), 32'h3);
      check("lat_e3_filt", 32'(a_filt), 32'h3);
      check("lat_e3_rise", 32'(a_rise), 32'h1);
      check("lat_e3_fall", 32'(a_fall), 32'h0);
      step(1);
      check("lat_e4_rise", 32'(a_rise), 32'h0);

      // ---------------- glitch rejection, FILTER_LEN=4 ----------------
      s0 = b_rise_n; s1 = b_fall_n;
      b_in = 1'b1;
      step(3);
      b_in = 1'b0;
      step(8);
      check("glitch3_filt", 32'(b_filt), 32'h0);
      check("glitch3_rise", 32'(b_rise_n - s0), 32'h0);
      check("glitch3_fall", 32'(b_fall_n - s1), 32'h0);

      s0 = b_rise_n; s1 = b_fall_n;
      b_in = 1'b1;
      step(4);
      b_in = 1'b0;
      step(1);
      check("pulse4_e5_filt", 32'(b_filt), 32'h0);
      step(1);
      check("pulse4_e6_filt", 32'(b_filt), 32'h1);
      check("pulse4_e6_rise", 32'(b_rise), 32'h1);
      step(3);
      check("pulse4_e9_filt", 32'(b_filt), 32'h1);
      step(1);
      check("pulse4_e10_filt", 32'(b_filt), 32'h0);
      check("pulse4_e10_fall", 32'(b_fall), 32'h1);
      step(3);
      check("pulse4_rise_cnt", 32'(b_rise_n - s0), 32'h1);
      check("pulse4_fall_cnt", 32'(b_fall_n - s1), 32'h1);

      // ---------------- counter restart: 1,1,1,0,1,1,1,1 ----------------
      begin
         logic [7:0] pat;
         pat = 8'b1111_0111;
         for (int k = 0; k < 8; k++) begin
            b_in = pat[k];
            step(1);
         end
      end
      step(1);
      check("restart_e9_filt", 32'(b_filt), 32'h0);
      step(1);
      check("restart_e10_filt", 32'(b_filt), 32'h1);
      check("restart_e10_rise", 32'(b_rise), 32'h1);
      b_in = 1'b0;
      step(8);
      check("restart_back_low", 32'(b_filt), 32'h0);

      // ---------------- channel independence, FILTER_LEN=2 ----------------
      s0 = c_quiet_n; s1 = c3_rise_n;
      c_in = 4'b1001;
      step(1);
      c_in[0] = ~c_in[0];
      step(1);
      c_in[0] = ~c_in[0];
      step(1);
      check("indep_e3_filt", 32'(c_filt), 32'h0);
      c_in[0] = ~c_in[0];
      step(1);
      check("indep_e4_filt", 32'(c_filt), 32'h8);
      check("indep_e4_rise", 32'(c_rise), 32'h8);
      check("indep_e4_fall", 32'(c_fall), 32'h0);
      for (int k = 0; k < 6; k++) begin
         c_in[0] = ~c_in[0];
         step(1);
      end
      c_in[0] = 1'b0;
      step(4);
      check("indep_final_filt", 32'(c_filt), 32'h8);
      check("indep_quiet_ch012", 32'(c_quiet_n - s0), 32'h0);
      check("indep_ch3_rise_cnt", 32'(c3_rise_n - s1), 32'h1);

      // ---------------- reset mid-count, FILTER_LEN=8 ----------------
      d_in = 1'b1;
      step(7);                      // counter now at 5
      check("mid_pre_filt", 32'(d_filt), 32'h0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_d_sync", 32'(d_sync), 32'h0);
      check("mid_rst_d_filt", 32'(d_filt), 32'h0);
      check("mid_rst_a_sync", 32'(a_sync), 32'h2);
      check("mid_rst_c_filt", 32'(c_filt), 32'h0);
      step(2);
      reset_n = 1'b1;
      step(2);
      check("mid_rel_sync", 32'(d_sync), 32'h1);
      step(7);
      check("mid_rel_e9_filt", 32'(d_filt), 32'h0);
      step(1);
      check("mid_rel_e10_filt", 32'(d_filt), 32'h1);
      check("mid_rel_e10_rise", 32'(d_rise), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multi_bit_synchronizer.md
Name: multi_bit_synchronizer

Overview:
Parametrised multi-channel CDC input conditioner for asynchronous board-level signals (UART RX line, buttons, handshake strobes) entering the `clk` domain. Each channel has:
- a configurable-depth flip-flop synchroniser chain;
- an optional glitch filter, set by a stability count;
- registered rising- and falling-edge pulse outputs.

It sits directly behind the pads and feeds the UART receiver and control logic. Channels are fully independent. There is no bus coherency, so it must not be used for multi-bit data words.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser flip-flops per channel. Legal range 2..4; elaboration error otherwise.
- FILTER_LEN, 0: stability count in cycles. 0 = filter bypassed. N >= 1 = filtered output changes only after the synchronised value has differed from it for N consecutive cycles. Legal range 0..255.
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset/idle value for all internal state and the level outputs. Use 1 for UART RX idle-high.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- sig_in  input  WIDTH  asynchronous input signals
- sig_sync_out  output  WIDTH  synchronised, unfiltered level
- sig_filt_out  output  WIDTH  filtered level; equals sig_sync_out when FILTER_LEN=0
- rise_pulse  output  WIDTH  one-cycle pulse on 0->1 of sig_filt_out
- fall_pulse  output  WIDTH  one-cycle pulse on 1->0 of sig_filt_out

Behaviour:

Reset (reset_n=0, asynchronous assert):
- All sync stages and filtered registers = RESET_VAL; sig_sync_out = sig_filt_out = RESET_VAL.
- Stability counters = 0; rise_pulse = fall_pulse = 0.
- Release is synchronous to clk as seen by downstream.
- No edge pulse is ever generated by reset assertion or release.

Sync chain:
- Value sampled from sig_in at rising edge k appears on sig_sync_out after edge k+STAGES-1, i.e. STAGES flops.
- No logic between stages.

Filter, FILTER_LEN = N >= 1, per channel:
- Counter width clog2(N+1). Define diff = (sig_sync_out != sig_filt_out).
- diff=0: counter cleared to 0.
- diff=1 and counter < N-1: counter increments.
- diff=1 and counter == N-1: sig_filt_out <= sig_sync_out and counter cleared.
- Result: a level change on sig_sync_out held for N cycles reaches sig_filt_out exactly N cycles later.
- Any return to the old value before then clears the counter, and the glitch is rejected.
- The counter never exceeds N-1 and never wraps.

Filter, FILTER_LEN = 0:
- sig_filt_out is a direct wire from sig_sync_out; no added latency.

Edge pulses:
- Registered, single-cycle, high in the first cycle sig_filt_out shows the new value.
- rise_pulse and fall_pulse are never both high on one channel.
- Maximum pulse rate is one per N cycles (filter on) or one per cycle (filter off). Back-to-back alternate toggles with FILTER_LEN=0 yield alternating rise/fall pulses every cycle.

Simultaneous events:
- Channels are independent; changes on different channels in the same cycle are processed in parallel with identical latency.

Reset mid-operation:
- A pending filter count is discarded and outputs return to RESET_VAL immediately.
- A pulse high at reset assertion is cleared asynchronously.

All outputs are driven from flops. The only exception is sig_filt_out when FILTER_LEN=0, which is a wire.

Test Plan:
- Reset values: WIDTH=2, RESET_VAL=2'b10, sig_in=2'b01 during reset -> sig_sync_out=sig_filt_out=2'b10 and pulses 0 while reset_n=0. After release with sig_in=2'b10 held, no pulse ever.
- Latency: STAGES=3, FILTER_LEN=0, sig_in 0->1 setup before edge 1 -> sig_sync_out and sig_filt_out high after edge 3. rise_pulse high for exactly the cycle after edge 3, then 0.
- Glitch rejection: STAGES=2, FILTER_LEN=4, sync-domain pulse of 3 cycles -> sig_filt_out stays 0, no pulses. A pulse of 4 cycles -> sig_filt_out rises 4 cycles after sig_sync_out, one rise_pulse. On return to 0 for 4+ cycles, one fall_pulse.
- Counter restart: FILTER_LEN=4, sig_sync_out pattern 1,1,1,0,1,1,1,1 -> sig_filt_out rises only after the final 4-cycle run. The count restarts after the 0.
- Channel independence: WIDTH=4, FILTER_LEN=2, channel 0 toggles every cycle, channel 3 steps 0->1 -> channel 0 never changes. Channel 3 gets one rise_pulse at the expected time; channels 1 and 2 stay quiet.
- Reset mid-count: FILTER_LEN=8, assert reset_n=0 when the counter is at 5 -> outputs = RESET_VAL immediately. After release, a new change needs a full 8 cycles.
